regfile_test_sequencer: RTL
===========================

Name: regfile_test_sequencer

Overview:
- Hardware self-check engine that drives the register file test port of skeleton_test in place of a simulation bench, so bypassing and forwarding results can be checked on the FPGA.
- After a programmable run window, it freezes the processor's view of the register file and walks a table of expected (register, value) pairs.
- It reads each register through both test read ports, compares, counts passes, and reports the first failure and a done flag.

Parameters:
- NUM_CHECKS, 9: number of entries in the expected-value table; must be 1..31.
- RUN_CYCLES, 100: clock cycles the processor runs after start before checking begins; must be ≥1.
- CNT_W, 8: width of the run counter and index counter; must satisfy 2^CNT_W > max(RUN_CYCLES, NUM_CHECKS).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  1-cycle pulse; begins a run from IDLE or DONE; ignored in all other states.
- chk_index  out  CNT_W  index of the table entry being checked; feeds the external combinational table.
- chk_reg  in  5  register number for table entry chk_index (combinational, same cycle).
- chk_value  in  32  expected value for table entry chk_index (combinational, same cycle).
- test  out  1  test-port select to skeleton_test; high only in ISSUE and SAMPLE.
- t_ctrl_writeEnable  out  1  test-port write enable; constant 0.
- t_ctrl_writeReg  out  5  constant 0.
- t_data_writeReg  out  32  constant 0.
- t_ctrl_readRegA  out  5  test read address, port A.
- t_ctrl_readRegB  out  5  test read address, port B; always equal to t_ctrl_readRegA.
- t_data_readRegA  in  32  test read data, port A.
- t_data_readRegB  in  32  test read data, port B.
- num_correct  out  CNT_W  count of passed checks.
- done  out  1  high in DONE state.
- all_pass  out  1  high in DONE when num_correct == NUM_CHECKS.
- fail_seen  out  1  sticky; set on the first failing check.
- fail_reg  out  5  register number of the first failure.
- fail_expected  out  32  expected value at the first failure.
- fail_actual  out  32  port A data at the first failure.

Behaviour:
- Reset values: all outputs are 0; the state is IDLE; the run counter and chk_index are 0.
- States:
  - IDLE: holds until start is asserted, then moves to RUN.
  - RUN: increments the run counter each cycle. After exactly RUN_CYCLES cycles in RUN it moves to ISSUE, so test rises on the RUN_CYCLES-th edge after start is sampled.
  - ISSUE: test=1; t_ctrl_readRegA and t_ctrl_readRegB = chk_reg, registered at entry and held through SAMPLE. Always moves to SAMPLE next cycle.
  - SAMPLE: test=1; data is compared on the rising edge that leaves SAMPLE. A check passes only when t_data_readRegA == chk_value AND t_data_readRegB == chk_value.
    - On pass, num_correct increments.
    - On fail with fail_seen=0, fail_seen is set and fail_reg, fail_expected and fail_actual are captured. Later failures do not overwrite these.
    - If chk_index == NUM_CHECKS-1, the next state is DONE. Otherwise chk_index increments and the next state is ISSUE.
  - DONE: test=0; done=1; all results are held. A start pulse clears num_correct, fail_*, chk_index and the run counter, and moves to RUN in the same edge.
- Timing:
  - Each check takes exactly 2 cycles.
  - A full sequence takes RUN_CYCLES + 2·NUM_CHECKS cycles from start to done.
- Test-port outputs:
  - t_ctrl_readRegA and t_ctrl_readRegB are 0 whenever test=0.
  - The writeEnable, writeReg and writeData outputs are never driven nonzero.
- chk_reg == 0 is a legal entry; it expects r0 and normally requires chk_value == 0.
- num_correct saturates at NUM_CHECKS. It cannot overflow, given the CNT_W constraint.
- Reset asserted mid-RUN, ISSUE or SAMPLE: test drops to 0 asynchronously, all results are cleared, and the state returns to IDLE. A start pulse coincident with reset is ignored.
- A start pulse during RUN, ISSUE or SAMPLE has no effect.

Test Plan:
- Table of 9 entries all matching a register-file model (e.g. r4=30, r6=21, r20=409); start → test rises after 100 cycles; done after 118 cycles; num_correct=9; all_pass=1; fail_seen=0.
- Entry 3 (r10, expect 21) with the model returning 22 on both ports → num_correct=8, fail_seen=1, fail_reg=10, fail_expected=21, fail_actual=22, all_pass=0.
- Entries 2 and 5 both mismatching → fail_* report entry 2 only; num_correct=7.
- Port A correct, port B corrupted for r8 (A=55, B=0) → that check fails; fail_actual=55.
- Reset asserted during the 4th SAMPLE → outputs return to 0 and the state to IDLE; a subsequent start runs a full clean sequence with num_correct=9.
- start pulsed during RUN has no effect on timing. start in DONE restarts the sequence, clearing num_correct to 0 on the next edge and raising done again after 118 cycles.

Source files
------------

// File: rtl/regfile_test_sequencer.sv
// regfile_test_sequencer
//   Hardware self-check engine for the skeleton_test register-file test port.
//   After start, the processor runs for RUN_CYCLES clocks. The sequencer then
//   takes over the test port and walks an external table of expected
//   (register, value) pairs. Each register is read through both test read
//   ports, passes are counted, and the first failure is captured.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start
//   RUN    | processor running, run counter advancing
//   ISSUE  | test port owned, read address presented for table entry
//   SAMPLE | read data compared against table on the exit edge
//   DONE   | results held, done=1, start restarts a run
//
// Ports
//   clock, reset (async, active-high), start (1-cycle pulse)
//   chk_index/chk_reg/chk_value : external combinational expected-value table
//   test, t_ctrl_*, t_data_*    : register-file test port of skeleton_test
//   num_correct, done, all_pass, fail_seen, fail_reg, fail_expected,
//   fail_actual                 : results
module regfile_test_sequencer #(
  parameter int NUM_CHECKS = 9,
  parameter int RUN_CYCLES = 100,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [CNT_W-1:0] chk_index,
  input  logic [4:0]       chk_reg,
  input  logic [31:0]      chk_value,
  output logic             test,
  output logic             t_ctrl_writeEnable,
  output logic [4:0]       t_ctrl_writeReg,
  output logic [31:0]      t_data_writeReg,
  output logic [4:0]       t_ctrl_readRegA,
  output logic [4:0]       t_ctrl_readRegB,
  input  logic [31:0]      t_data_readRegA,
  input  logic [31:0]      t_data_readRegB,
  output logic [CNT_W-1:0] num_correct,
  output logic             done,
  output logic             all_pass,
  output logic             fail_seen,
  output logic [4:0]       fail_reg,
  output logic [31:0]      fail_expected,
  output logic [31:0]      fail_actual
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ISSUE, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] CHK_TOTAL = CNT_W'(NUM_CHECKS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_cnt;
  logic [4:0]       read_reg;
  logic             go;
  logic             check_ok;

  // start is only honoured when no run is in flight
  assign go       = start && ((state == S_IDLE) || (state == S_DONE));
  // both ports must agree with the table for a pass
  assign check_ok = (t_data_readRegA == chk_value) && (t_data_readRegB == chk_value);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_RUN;
      S_RUN:    if (run_cnt == RUN_LAST) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (chk_index == CHK_LAST) ? S_DONE : S_ISSUE;
      S_DONE:   if (go) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt       <= '0;
      chk_index     <= '0;
      read_reg      <= '0;
      num_correct   <= '0;
      fail_seen     <= 1'b0;
      fail_reg      <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            run_cnt       <= '0;
            chk_index     <= '0;
            num_correct   <= '0;
            fail_seen     <= 1'b0;
            fail_reg      <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
          end
        end
        S_RUN:   run_cnt <= run_cnt + 1'b1;
        // chk_index is stable across ISSUE/SAMPLE, so the address latched
        // here is the one the register file sees for the whole check
        S_ISSUE: read_reg <= chk_reg;
        S_SAMPLE: begin
          if (check_ok) begin
            if (num_correct != CHK_TOTAL) num_correct <= num_correct + 1'b1;
          end else if (!fail_seen) begin
            fail_seen     <= 1'b1;
            fail_reg      <= read_reg;
            fail_expected <= chk_value;
            fail_actual   <= t_data_readRegA;
          end
          if (chk_index != CHK_LAST) chk_index <= chk_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    test               = 1'b0;
    done               = 1'b0;
    t_ctrl_readRegA    = '0;
    t_ctrl_writeEnable = 1'b0;
    t_ctrl_writeReg    = '0;
    t_data_writeReg    = '0;
    case (state)
      // address goes out on ISSUE entry straight from the table, then from
      // the latched copy so SAMPLE does not depend on the table path
      S_ISSUE: begin
        test            = 1'b1;
        t_ctrl_readRegA = chk_reg;
      end
      S_SAMPLE: begin
        test            = 1'b1;
        t_ctrl_readRegA = read_reg;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    t_ctrl_readRegB = t_ctrl_readRegA;
  end

  assign all_pass = done && (num_correct == CHK_TOTAL);

endmodule
